// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/acknowledge bus between the MEM stage and data memory
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: load/store over a req/ack data bus with stall, formatting and faults
module mem_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_mem_memread,
  input  logic                ex_mem_memwrite,
  input  logic [2:0]          ex_mem_funct3,
  input  logic [31:0]         result_ex_mem,
  input  logic [31:0]         ex_mem_write_data,
  output logic [31:0]         read_data,
  output logic                mem_stall,
  output logic                mem_fault,
  mem_access_stage_if.master  dmem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_stall;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_read_data;
  logic        r_fault;

  logic        w_load;
  logic        w_store;
  logic        w_both;
  logic        w_bad_f3;
  logic        w_misalign;
  logic        w_legal;
  logic        w_fault_idle;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_load  = ex_mem_memread & ~ex_mem_memwrite;
  assign w_store = ex_mem_memwrite & ~ex_mem_memread;
  assign w_both  = ex_mem_memread & ex_mem_memwrite;

  // Reserved funct3 encodings differ for loads (011/11x) and stores (only 000..010 legal)
  assign w_bad_f3 = w_load  ? ((ex_mem_funct3 == 3'b011) || (ex_mem_funct3[2:1] == 2'b11)) :
                    w_store ? (ex_mem_funct3[2] || (ex_mem_funct3[1:0] == 2'b11)) : 1'b0;

  assign w_misalign = ((ex_mem_funct3[1:0] == 2'b01) & result_ex_mem[0]) |
                      ((ex_mem_funct3[1:0] == 2'b10) & (|result_ex_mem[1:0]));

  assign w_legal      = (w_load | w_store) & ~w_bad_f3 & ~w_misalign;
  assign w_fault_idle = w_both | ((w_load | w_store) & (w_bad_f3 | w_misalign));
  assign w_timeout    = (r_cnt == CW'(TIMEOUT - 1));

  // Store lane replication and byte enables from size and low address bits
  always_comb begin
    w_wdata = ex_mem_write_data;
    w_wstrb = 4'b1111;
    case (ex_mem_funct3[1:0])
      2'b00: begin
        w_wdata = {4{ex_mem_write_data[7:0]}};
        w_wstrb = 4'b0001 << result_ex_mem[1:0];
      end
      2'b01: begin
        w_wdata = {2{ex_mem_write_data[15:0]}};
        w_wstrb = result_ex_mem[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = ex_mem_write_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and sign/zero extension using the latched size and lane
  always_comb begin
    w_byte = dmem.dmem_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = dmem.dmem_rdata[7:0];
      2'd1: w_byte = dmem.dmem_rdata[15:8];
      2'd2: w_byte = dmem.dmem_rdata[23:16];
      default: w_byte = dmem.dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = dmem.dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and stall; DONE never stalls so the pipeline advances past the access
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_legal) begin
          w_stall = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (dmem.dmem_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gated by rst_n so stall drops at once during reset even if EX/MEM still holds an access
  assign mem_stall = w_stall & rst_n;

  // Bus request, counter, load result and fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_cnt       <= '0;
      r_read_data <= 32'd0;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fault_idle) begin
            r_fault     <= 1'b1;
            r_read_data <= 32'd0;
          end else if (w_legal) begin
            r_req    <= 1'b1;
            r_we     <= w_store;
            r_addr   <= {result_ex_mem[31:2], 2'b00};
            r_wdata  <= w_wdata;
            r_wstrb  <= w_store ? w_wstrb : 4'b0000;
            r_funct3 <= ex_mem_funct3;
            r_lane   <= result_ex_mem[1:0];
            r_cnt    <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (dmem.dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_read_data <= w_load_data;
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_fault     <= 1'b1;
            r_read_data <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_wstrb = r_wstrb;
  assign read_data       = r_read_data;
  assign mem_fault       = r_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] result_ex_mem;
  logic [31:0] ex_mem_write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        mem_fault;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_memread    (ex_mem_memread),
    .ex_mem_memwrite   (ex_mem_memwrite),
    .ex_mem_funct3     (ex_mem_funct3),
    .result_ex_mem     (result_ex_mem),
    .ex_mem_write_data (ex_mem_write_data),
    .read_data         (read_data),
    .mem_stall         (mem_stall),
    .mem_fault         (mem_fault),
    .dmem              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stalls;
    logic        fault;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdv;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_k;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          stalls;
    int          reqs;
    int          faults;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdv;
    bit          unstable;
    bit          extra_busy;
    bit          timed_out;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[15];
  logic [31:0] m_read;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: access outcome computed from size, lane and legality rules
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int ack_k,
                                 input logic [31:0] prev);
    exp_t e;
    int size;
    int lane;
    bit legal;
    logic [31:0] mask;
    logic [31:0] v;
    e = '{default: 0};
    e.rdv = prev;
    if (!rd && !wr) return e;
    size  = 1 << f3[1:0];
    lane  = int'(addr % 32'd4);
    legal = !(rd && wr);
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 0;
    if (wr && f3 > 3'd2) legal = 0;
    if (legal && (addr % 32'(size)) != 0) legal = 0;
    if (!legal) begin
      e.fault = 1'b1;
      e.rdv   = 32'd0;
      return e;
    end
    e.addr = addr & 32'hFFFF_FFFC;
    e.we   = wr;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (wr) begin
      e.wstrb = 4'(((1 << size) - 1) << lane);
      e.wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    end
    if (ack_k < 1 || ack_k > TIMEOUT) begin
      e.stalls = TIMEOUT + 1;
      e.fault  = 1'b1;
      e.rdv    = 32'd0;
    end else begin
      e.stalls = ack_k + 1;
      if (rd) begin
        v = (rdata >> (8 * lane)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        e.rdv = v;
      end
    end
    return e;
  endfunction

  // Presents one EX/MEM instruction and plays the memory side; ack in WAIT cycle ack_k (0 = never)
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_k, output obs_t o);
    int w;
    bit fin;
    bit first;
    o = '{default: 0};
    ex_mem_memread    = rd;
    ex_mem_memwrite   = wr;
    ex_mem_funct3     = f3;
    result_ex_mem     = addr;
    ex_mem_write_data = wd;
    w = 0;
    fin = 0;
    first = 1;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        w++;
        o.reqs++;
        if (first) begin
          o.addr = bus.dmem_addr; o.we = bus.dmem_we;
          o.wstrb = bus.dmem_wstrb; o.wdata = bus.dmem_wdata;
          first = 0;
        end else if (o.addr !== bus.dmem_addr || o.we !== bus.dmem_we ||
                     o.wstrb !== bus.dmem_wstrb || o.wdata !== bus.dmem_wdata) begin
          o.unstable = 1;
        end
      end
      if (mem_stall) o.stalls++;
      else fin = 1;
      if (mem_fault) o.faults++;
      if (bus.dmem_req && w == ack_k) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end else begin
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      bus.dmem_ack = 1'b0;
    end
    o.timed_out = !fin;
    ex_mem_memread  = 1'b0;
    ex_mem_memwrite = 1'b0;
    ex_mem_funct3   = 3'($urandom);
    result_ex_mem   = $urandom;
    @(negedge clk);
    if (mem_fault) o.faults++;
    o.extra_busy = bus.dmem_req | mem_stall;
    o.rdv = read_data;
    @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input obs_t o, input exp_t e);
    check({tag, " stalls"}, o.stalls, e.stalls);
    check({tag, " req_cycles"}, o.reqs, (e.stalls > 0) ? e.stalls - 1 : 0);
    check({tag, " fault_pulses"}, o.faults, 32'(e.fault));
    check({tag, " read_data"}, o.rdv, e.rdv);
    check({tag, " idle_after"}, 32'(o.extra_busy), 32'd0);
    check({tag, " completed"}, 32'(o.timed_out), 32'd0);
    if (e.stalls > 0) begin
      check({tag, " dmem_addr"}, o.addr, e.addr);
      check({tag, " dmem_we"}, 32'(o.we), 32'(e.we));
      check({tag, " dmem_wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
      if (e.we) check({tag, " dmem_wdata"}, o.wdata, e.wdata);
      check({tag, " bus_stable"}, 32'(o.unstable), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    obs_t o;
    exp_t e;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdata;
    int ack_k, r;
    int seen_fault, seen_req;

    ex_mem_memread = 0; ex_mem_memwrite = 0; ex_mem_funct3 = 0;
    result_ex_mem = 0; ex_mem_write_data = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset read_data", read_data, 32'd0);
    check("reset mem_stall", 32'(mem_stall), 32'd0);
    check("reset mem_fault", 32'(mem_fault), 32'd0);
    check("reset dmem_req", 32'(bus.dmem_req), 32'd0);
    check("reset dmem_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    check("reset dmem_addr", bus.dmem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80AB_CDEF, 1, '{2, 1'b0, 32'h100, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80}};
    tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 32'hFFFF_0000, 1, '{2, 1'b0, 32'h200, 1'b1, 4'b1100, 32'h5678_5678, 32'hFFFF_FF80}};
    tbl[2]  = '{1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_9ABC, 4, '{5, 1'b0, 32'h10, 1'b0, 4'b0000, 32'h0, 32'h0000_9ABC}};
    tbl[3]  = '{1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1, '{0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0}};
    tbl[4]  = '{1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 1, '{0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0}};
    tbl[5]  = '{1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 32'h0000_7F00, 2, '{3, 1'b0, 32'h20, 1'b0, 4'b0000, 32'h0, 32'h0000_007F}};
    tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h33, 32'hAABB_CCDD, 32'h0, 1, '{2, 1'b0, 32'h30, 1'b1, 4'b1000, 32'hDDDD_DDDD, 32'h0000_007F}};
    tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h0, 0, '{16, 1'b1, 32'h40, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0}};
    tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h1357_9BDF, 15, '{16, 1'b0, 32'h44, 1'b0, 4'b0000, 32'h0, 32'h1357_9BDF}};
    tbl[9]  = '{1'b1, 1'b1, 3'b010, 32'h8, 32'h0, 32'h0, 1, '{0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0}};
    tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, '{0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0}};
    tbl[11] = '{1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1, '{0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0}};
    tbl[12] = '{1'b1, 1'b0, 3'b001, 32'h2E, 32'h0, 32'h8001_1234, 3, '{4, 1'b0, 32'h2C, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001}};
    tbl[13] = '{1'b1, 1'b0, 3'b100, 32'h2, 32'h0, 32'h00F0_0000, 1, '{2, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_00F0}};
    tbl[14] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0, 32'h0, 1, '{0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0}};

    for (int i = 0; i < 15; i++) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdata, tbl[i].ack_k, o);
      verify($sformatf("row%0d", i), o, tbl[i].e);
    end
    m_read = tbl[14].e.rdv;

    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5);
      wr = (r >= 4 && r < 9);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd = $urandom;
      rdata = $urandom;
      r = $urandom_range(0, 19);
      ack_k = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 5);
      e = model(rd, wr, f3, addr, wd, rdata, ack_k, m_read);
      run_access(rd, wr, f3, addr, wd, rdata, ack_k, o);
      verify($sformatf("rand%0d", i), o, e);
      m_read = e.rdv;
    end

    e = model(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'hA5A5_5A5A, 1, m_read);
    run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'hA5A5_5A5A, 1, o);
    verify("lw_before_idle_ack", o, e);
    m_read = e.rdv;

    seen_fault = 0;
    seen_req = 0;
    bus.dmem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.dmem_rdata = $urandom;
      @(negedge clk);
      if (mem_fault) seen_fault++;
      if (bus.dmem_req || mem_stall) seen_req++;
      @(posedge clk);
      #1;
    end
    bus.dmem_ack = 1'b0;
    check("idle_ack read_data", read_data, m_read);
    check("idle_ack fault", seen_fault, 0);
    check("idle_ack busy", seen_req, 0);

    ex_mem_memread = 1'b1; ex_mem_memwrite = 1'b0;
    ex_mem_funct3 = 3'b010; result_ex_mem = 32'h88;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_mid pre dmem_req", 32'(bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_mid mem_stall", 32'(mem_stall), 32'd0);
    check("rst_mid read_data", read_data, 32'd0);
    check("rst_mid mem_fault", 32'(mem_fault), 32'd0);
    ex_mem_memread = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release idle", 32'(bus.dmem_req | mem_stall), 32'd0);
    m_read = 32'd0;
    rdata = $urandom;
    e = model(1'b1, 1'b0, 3'b010, 32'h8C, 32'h0, rdata, 2, m_read);
    run_access(1'b1, 1'b0, 3'b010, 32'h8C, 32'h0, rdata, 2, o);
    verify("lw_after_reset", o, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
